// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready word intake.
// Latency: first serial bit appears the cycle after a word is accepted; frames are contiguous when back-to-back.
// Backpressure: in_ready is high only in IDLE or in the final-bit cycle of a frame; words are held off otherwise.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   rst_n      - asynchronous active-low reset
//   in_data    - parallel word to serialize (WIDTH bits)
//   in_valid   - in_data is valid
//   in_ready   - a word is accepted this cycle when in_valid is also high
//   ser_out    - serial bit towards the downstream shift-register chain
//   ser_valid  - ser_out carries a frame bit this cycle
//   busy       - a frame is in progress
//   frame_done - one-cycle pulse on the final bit of a frame
//
// Parameters: WIDTH (2..32), MSB_FIRST (1: bit WIDTH-1 first, 0: bit 0 first).
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the accepted word) after the data bits, giving WIDTH+1 bit frames.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             accept;
  logic             do_load;
  logic             head_bit;
  logic             first_bit;
  logic [WIDTH-1:0] shreg_shifted;
  logic [WIDTH-1:0] load_shifted;

  // frame_done_q marks the final-bit cycle, which is exactly when a new
  // word may be taken alongside IDLE. Gating with rst_n keeps in_ready low
  // while reset is held and lets it rise in the first cycle after release.
  assign in_ready = rst_n & ((state_q == IDLE) | frame_done_q);
  assign accept   = in_valid & in_ready;

  // The register holds the bits still to be sent; the bit on ser_out has
  // already been shifted out, so a load stores the word pre-shifted by one.
  always_comb begin
    if (MSB_FIRST) begin
      head_bit      = shreg_q[WIDTH-1];
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      first_bit     = in_data[WIDTH-1];
      load_shifted  = {in_data[WIDTH-2:0], 1'b0};
    end else begin
      head_bit      = shreg_q[0];
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      first_bit     = in_data[0];
      load_shifted  = {1'b0, in_data[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    do_load      = 1'b0;
`ifdef PISO_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        do_load = accept;
      end

      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d       = cnt_q + CW'(1);
          shreg_d     = shreg_shifted;
          ser_out_d   = head_bit;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
`ifndef PISO_PARITY_EN
          // Next cycle presents bit WIDTH-1, the final bit of the frame.
          frame_done_d = (cnt_q == PENULT);
`endif
        end else begin
`ifdef PISO_PARITY_EN
          state_d      = PAR;
          cnt_d        = '0;
          shreg_d      = '0;
          ser_out_d    = par_q;
          ser_valid_d  = 1'b1;
          busy_d       = 1'b1;
          frame_done_d = 1'b1;
`else
          if (accept) begin
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
          end
`endif
        end
      end

`ifdef PISO_PARITY_EN
      PAR: begin
        if (accept) begin
          do_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase

    // A load overrides whatever the current state decided; it is taken
    // from IDLE or from the final-bit cycle so frames run back-to-back.
    if (do_load) begin
      state_d      = SHIFT;
      shreg_d      = load_shifted;
      cnt_d        = '0;
      ser_out_d    = first_bit;
      ser_valid_d  = 1'b1;
      busy_d       = 1'b1;
      frame_done_d = 1'b0;
`ifdef PISO_PARITY_EN
      par_d        = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef PISO_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: drives one word stream into an MSB-first and an LSB-first piso_tx.
// Latency: expected bits are queued at acceptance and compared on every falling edge.
// Backpressure: words are only presented once both instances show in_ready.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  typedef struct packed {
    logic b;
    logic done;
  } exp_t;

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq_msb;  // bit 7 is sent first
    logic [7:0] seq_lsb;  // bit 7 is sent first
    logic       par;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       rdy_m, so_m, sv_m, bz_m, fd_m;
  logic       rdy_l, so_l, sv_l, bz_l, fd_l;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   vld_cnt  = 0;
  int   fd_cnt   = 0;
  vec_t vecs[6];

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m), .busy(bz_m),
    .frame_done(fd_m)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l), .busy(bz_l),
    .frame_done(fd_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] sm, input logic [7:0] sl, input logic p);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
      e.done = 1'b0;
`else
      e.done = (i == 0);
`endif
      e.b = sm[i];
      q0.push_back(e);
      e.b = sl[i];
      q1.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.b    = p;
    e.done = 1'b1;
    q0.push_back(e);
    q1.push_back(e);
`else
    if (p) e.b = 1'b0;  // parity bit is not part of the frame in this build
`endif
  endtask

  task automatic mon(input int d, input logic so, input logic sv, input logic bz,
                     input logic fd, input logic rdy);
    exp_t  e;
    logic  have;
    string tag;
    tag  = (d == 0) ? "msb" : "lsb";
    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (!rst_n) begin
      chkn({tag, "_reset_outputs"}, int'({so, sv, bz, fd, rdy}), 0);
    end else if (sv) begin
      chk1({tag, "_bit_expected"}, have, 1'b1);
      if (have) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk1({tag, "_ser_out"}, so, e.b);
        chk1({tag, "_frame_done"}, fd, e.done);
        chk1({tag, "_busy"}, bz, 1'b1);
      end
    end else begin
      chkn({tag, "_idle_or_gap"}, int'({have, so, bz, fd}), 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end
    mon(0, so_m, sv_m, bz_m, fd_m, rdy_m);
    mon(1, so_l, sv_l, bz_l, fd_l, rdy_l);
    if (rst_n && sv_m) vld_cnt++;
    if (rst_n && fd_m) fd_cnt++;
  end

  // Present a word once both instances are ready; returns just after the
  // accepting edge with the expected stream already queued.
  task automatic send(input logic [7:0] w, input bit keep, input logic [7:0] sm,
                      input logic [7:0] sl, input logic p);
    int n = 0;
    @(negedge clk);
    while (!(rdy_m && rdy_l) && n < 40) begin
      if (!in_valid) in_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    chk1("send_ready_in_time", (n < 40), 1'b1);
    #1;
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    push_frame(sm, sl, p);
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = ~w;
    end
  endtask

  // Wait for the frame to drain while scrambling in_data every cycle.
  task automatic wait_idle();
    int n = 0;
    while ((bz_m || bz_l || q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      if (!in_valid) in_data = 8'($urandom);
      n++;
    end
    chk1("idle_in_time", (n < 60), 1'b1);
    #1;
    chk1("msb_ready_after_frame", rdy_m, 1'b1);
    chk1("lsb_ready_after_frame", rdy_l, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{word: 8'hA5, seq_msb: 8'hA5, seq_lsb: 8'hA5, par: 1'b0};
    vecs[1] = '{word: 8'h01, seq_msb: 8'h01, seq_lsb: 8'h80, par: 1'b1};
    vecs[2] = '{word: 8'h0F, seq_msb: 8'h0F, seq_lsb: 8'hF0, par: 1'b0};
    vecs[3] = '{word: 8'h12, seq_msb: 8'h12, seq_lsb: 8'h48, par: 1'b0};
    vecs[4] = '{word: 8'h07, seq_msb: 8'h07, seq_lsb: 8'hE0, par: 1'b1};
    vecs[5] = '{word: 8'h03, seq_msb: 8'h03, seq_lsb: 8'hC0, par: 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    chkn("reset_state_msb", int'({so_m, sv_m, bz_m, fd_m, rdy_m}), 0);
    chkn("reset_state_lsb", int'({so_l, sv_l, bz_l, fd_l, rdy_l}), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk1("msb_ready_after_release", rdy_m, 1'b1);
    chk1("lsb_ready_after_release", rdy_l, 1'b1);

    // Single frames with idle gaps; in_data scrambled while busy.
    for (int k = 0; k < 6; k++) begin
      fd_cnt = 0;
      send(vecs[k].word, 1'b0, vecs[k].seq_msb, vecs[k].seq_lsb, vecs[k].par);
      wait_idle();
      chkn("frame_done_pulses_single", fd_cnt, 1);
    end

    // Back-to-back FF then 00 with in_valid held high.
    repeat (2) @(negedge clk);
    vld_cnt = 0;
    fd_cnt  = 0;
    send(8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b0);
    send(8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_idle();
    chkn("b2b_valid_cycles", vld_cnt, 2 * FL);
    chkn("b2b_frame_done_pulses", fd_cnt, 2);

    // Reset asserted during the third bit of C3.
    fd_cnt = 0;
    send(8'hC3, 1'b0, 8'hC3, 8'hC3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chkn("async_reset_msb", int'({so_m, sv_m, bz_m, fd_m, rdy_m}), 0);
    chkn("async_reset_lsb", int'({so_l, sv_l, bz_l, fd_l, rdy_l}), 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk1("msb_ready_after_midframe_reset", rdy_m, 1'b1);
    vld_cnt = 0;
    repeat (4) @(negedge clk);
    chkn("no_bits_after_reset", vld_cnt, 0);
    chkn("no_frame_done_on_abort", fd_cnt, 0);
    send(8'h81, 1'b0, 8'h81, 8'h81, 1'b0);
    wait_idle();
    chkn("frame_after_reset_done", fd_cnt, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 ser_out  output  1  serial bit, feeds the downstream shift-register chain.
REQ-009 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-010 busy  output  1  a frame is in progress.
REQ-011 frame_done  output  1  one-cycle pulse on the final bit of a frame.

Function
REQ-012 The block SHALL have states IDLE and SHIFT, plus PAR when PISO_PARITY_EN is defined.
REQ-013 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be latched into an internal WIDTH-bit shift register.
REQ-014 in_ready SHALL be 1 in IDLE and in the final-bit cycle of a frame; 0 otherwise; it SHALL NOT depend combinationally on in_valid.
REQ-015 Latency: the first bit of an accepted word SHALL appear on ser_out, with ser_valid=1, in the cycle after acceptance.
REQ-016 In SHIFT, ser_out SHALL present one data bit per cycle in the MSB_FIRST order, for exactly WIDTH consecutive cycles, tracked by a bit counter of width clog2(WIDTH), counting 0..WIDTH-1.
REQ-017 Without parity, SHIFT SHALL exit on bit count WIDTH-1, to IDLE if no word is accepted, or stay in SHIFT with the counter cleared if a word is accepted that edge.
REQ-018 Back-to-back: a word accepted in a final-bit cycle SHALL start its first bit the next cycle, with no gap cycle and ser_valid held at 1.
REQ-019 frame_done SHALL be 1 in exactly the final-bit cycle of each frame; busy SHALL be 1 in every SHIFT/PAR cycle.
REQ-020 In IDLE, ser_out SHALL be 0, ser_valid 0 and busy 0.
REQ-021 in_data changes while busy SHALL NOT affect the frame in flight.

Reset
REQ-022 On rst_n=0, the block SHALL immediately and asynchronously enter IDLE and clear the shift register, bit counter, ser_out, ser_valid, busy, frame_done and in_ready to 0.
REQ-023 In the first clock cycle after rst_n rises, in_ready SHALL be 1.
REQ-024 Reset mid-frame SHALL abort the frame with no frame_done pulse; no remaining bits SHALL be sent after reset release.

Configuration
REQ-025 With macro PISO_PARITY_EN defined, after the WIDTH data bits the block SHALL enter PAR for one cycle and emit the even-parity bit (XOR of the accepted word) with ser_valid=1; PAR is then the final-bit cycle for REQ-014/017/019, so frames are WIDTH+1 cycles.
REQ-026 Without PISO_PARITY_EN, the PAR state and parity logic SHALL be absent, and frames SHALL be exactly WIDTH cycles.

Verification
REQ-027 Reset release, then WIDTH=8, MSB_FIRST=1, in_data=8'hA5 accepted once -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_done on the 8th; then IDLE with in_ready=1.
REQ-028 MSB_FIRST=0, in_data=8'h01 -> ser_out 1,0,0,0,0,0,0,0.
REQ-029 Back-to-back: 8'hFF then 8'h00 with in_valid held high -> 16 contiguous ser_valid cycles, ser_out eight 1s then eight 0s, and two frame_done pulses on cycles 8 and 16.
REQ-030 rst_n pulled low on the 3rd bit of 8'hC3 -> outputs 0 in the same cycle, no frame_done; the next word 8'h81 is sent intact.
REQ-031 PISO_PARITY_EN defined: 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 with frame_done on bit 9; 8'h03 -> parity bit 0.
REQ-032 in_data toggled every cycle while busy with in_valid=0 -> the serialized frame equals the originally accepted word.
